// File: rtl/bin_to_gray_4bit_pkg.sv
// Shared Gray-code helpers: width, encode/decode functions, one-hot test.
package bin_to_gray_4bit_pkg;

    localparam int unsigned GRAY_W = 4;

    typedef logic [GRAY_W-1:0] code_t;

    // Reflected-binary encode: each bit is the XOR of itself and its upper neighbour.
    function automatic code_t bin2gray(input code_t b);
        return b ^ (b >> 1);
    endfunction

    // Decode: each binary bit is the running XOR of all Gray bits at or above it.
    function automatic code_t gray2bin(input code_t g);
        code_t b;
        b = '0;
        b[GRAY_W-1] = g[GRAY_W-1];
        for (int i = int'(GRAY_W) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input code_t v);
        return (v != '0) && ((v & (v - code_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/gray_to_bin_4bit.sv
// Combinational Gray-to-binary decoder.
module gray_to_bin_4bit
    import bin_to_gray_4bit_pkg::*;
(
    input  logic [GRAY_W-1:0] gray,
    output logic [GRAY_W-1:0] bin
);

    // Prefix-XOR decode from the MSB down.
    always_comb begin
        bin = gray2bin(gray);
    end

endmodule

// File: rtl/bin_to_gray_4bit.sv
// 4-bit binary-to-Gray converter with a registered observation stage.
module bin_to_gray_4bit
    import bin_to_gray_4bit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [GRAY_W-1:0] bin,
    output logic [GRAY_W-1:0] gray,
    output logic [GRAY_W-1:0] gray_q,
    output logic [GRAY_W-1:0] bin_dec,
    output logic [GRAY_W-1:0] gray_diff,
    output logic              single_flip
);

    logic [GRAY_W-1:0] diff_d;

    // Zero-latency encode; independent of clk and rst.
    always_comb begin
        gray = bin ^ (bin >> 1);
    end

    // Bit-flip mask between the incoming code and the last registered one.
    always_comb begin
        diff_d = gray ^ gray_q;
    end

    // Observation register bank; reset discards history so the next edge compares against zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gray_q      <= '0;
            gray_diff   <= '0;
            single_flip <= 1'b0;
        end else begin
            gray_q      <= gray;
            gray_diff   <= diff_d;
            single_flip <= is_onehot(diff_d);
        end
    end

    gray_to_bin_4bit u_dec (
        .gray (gray_q),
        .bin  (bin_dec)
    );

endmodule

// File: tb/tb_bin_to_gray_4bit.sv
// Self-checking bench for bin_to_gray_4bit: reference model plus directed literal checks.
module tb_bin_to_gray_4bit;

    logic       clk;
    logic       rst;
    logic [3:0] bin;
    logic [3:0] gray;
    logic [3:0] gray_q;
    logic [3:0] bin_dec;
    logic [3:0] gray_diff;
    logic       single_flip;

    int  checks;
    int  errors;
    bit  run_clk;
    bit  chk_en;

    // Reference model state: the bin value captured at the last edge.
    logic [3:0] m_bin_q;
    logic [3:0] m_diff;
    logic       m_sf;

    bin_to_gray_4bit dut (
        .clk         (clk),
        .rst         (rst),
        .bin         (bin),
        .gray        (gray),
        .gray_q      (gray_q),
        .bin_dec     (bin_dec),
        .gray_diff   (gray_diff),
        .single_flip (single_flip)
    );

    // Clock only runs once the combinational-only phase is over.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (run_clk) clk = ~clk;
        end
    end

    // Gray code as arithmetic: value XOR value/2.
    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ 4'(b / 2);
    endfunction

    // Model: remember the previous bin; flip mask is the Gray distance to it.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_bin_q <= 4'd0;
            m_diff  <= 4'd0;
            m_sf    <= 1'b0;
        end else begin
            m_bin_q <= bin;
            m_diff  <= to_gray(bin) ^ to_gray(m_bin_q);
            m_sf    <= ($countones(to_gray(bin) ^ to_gray(m_bin_q)) == 1);
        end
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_gray",    gray,           to_gray(bin));
            check("model_gray_q",  gray_q,         to_gray(m_bin_q));
            check("model_bin_dec", bin_dec,        m_bin_q);
            check("model_diff",    gray_diff,      m_diff);
            check("model_sf",      {3'b0, single_flip}, {3'b0, m_sf});
        end
    end

    // Drive bin just after a falling edge, return just after the next rising edge.
    task automatic apply(input logic [3:0] b);
        @(negedge clk);
        #1 bin = b;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] gray_tab [16];

    initial begin
        gray_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                     4'b0110, 4'b0111, 4'b0101, 4'b0100,
                     4'b1100, 4'b1101, 4'b1111, 4'b1110,
                     4'b1010, 4'b1011, 4'b1001, 4'b1000};
        checks  = 0;
        errors  = 0;
        run_clk = 1'b0;
        chk_en  = 1'b0;
        rst     = 1'b1;
        bin     = 4'd0;

        // Exhaustive encode with no clock, rst held high then low.
        for (int r = 0; r < 2; r++) begin
            rst = (r == 0);
            for (int i = 0; i < 16; i++) begin
                bin = 4'(i);
                #10;
                check("comb_gray", gray, gray_tab[i]);
                check("model_pin", to_gray(bin), gray_tab[i]);
            end
        end

        // Reset state, then clocked count 0..15.
        rst = 1'b1;
        bin = 4'd0;
        #3;
        check("rst_gray_q",  gray_q,    4'b0000);
        check("rst_bin_dec", bin_dec,   4'b0000);
        check("rst_diff",    gray_diff, 4'b0000);
        check("rst_sf",      {3'b0, single_flip}, 4'b0000);
        run_clk = 1'b1;
        chk_en  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;

        apply(4'd0);
        check("cnt0_diff", gray_diff, 4'b0000);
        for (int i = 1; i < 16; i++) begin
            apply(4'(i));
            check("cnt_sf",      {3'b0, single_flip}, 4'b0001);
            check("cnt_bin_dec", bin_dec, 4'(i));
            if (i == 1) check("cnt_diff_0to1", gray_diff, 4'b0001);
            if (i == 2) check("cnt_diff_1to2", gray_diff, 4'b0010);
            if (i == 8) check("cnt_diff_7to8", gray_diff, 4'b1000);
        end

        // Wrap-around 15 -> 0.
        apply(4'd0);
        check("wrap_diff", gray_diff, 4'b1000);
        check("wrap_sf",   {3'b0, single_flip}, 4'b0001);

        // Non-adjacent step 0 -> 5.
        apply(4'b0101);
        check("jump_diff",   gray_diff, 4'b0111);
        check("jump_sf",     {3'b0, single_flip}, 4'b0000);
        check("jump_gray_q", gray_q, 4'b0111);

        // Hold for three cycles.
        for (int k = 0; k < 3; k++) begin
            apply(4'b0101);
            check("hold_diff", gray_diff, 4'b0000);
            check("hold_sf",   {3'b0, single_flip}, 4'b0000);
        end

        // Asynchronous reset mid-stream with gray_q = 1010.
        apply(4'b1100);
        check("pre_rst_gray_q", gray_q, 4'b1010);
        #2 rst = 1'b1;
        #1;
        check("arst_gray_q",  gray_q,    4'b0000);
        check("arst_diff",    gray_diff, 4'b0000);
        check("arst_sf",      {3'b0, single_flip}, 4'b0000);
        check("arst_bin_dec", bin_dec,   4'b0000);
        bin = 4'b0011;
        #1;
        check("arst_gray_tracks", gray, 4'b0010);
        @(negedge clk);
        #1 begin
            rst = 1'b0;
            bin = 4'b0001;
        end
        @(posedge clk);
        #1;
        check("post_rst_diff", gray_diff, 4'b0001);
        check("post_rst_sf",   {3'b0, single_flip}, 4'b0001);
        check("post_rst_gq",   gray_q, 4'b0001);

        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_gray_4bit.md
# bin_to_gray_4bit

4-bit binary-to-Gray code converter with a registered observation stage. The combinational output `gray` gives the reflected-binary Gray code of `bin` with zero latency. It does not depend on the clock or reset. A clocked side-path registers the code, decodes it back to binary, and flags whether successive registered codes differ in exactly one bit. The block sits between binary counters/pointers and any consumer that needs single-bit-change encoding, such as clock-domain-crossing pointer paths and rotary/position encoders.

## Interface
Parameters:
- None; width is fixed at 4 bits.

Ports:
- `clk` — input, 1 bit — rising-edge clock for the registered stage.
- `rst` — input, 1 bit — reset; asynchronous, active-high. Clears all registered outputs.
- `bin` — input, 4 bits — binary value to convert.
- `gray` — output, 4 bits — combinational Gray code of `bin`.
- `gray_q` — output, 4 bits — `gray` registered on `clk`.
- `bin_dec` — output, 4 bits — binary decode of `gray_q` (combinational from `gray_q`).
- `gray_diff` — output, 4 bits — registered bit-flip mask, `gray ^ gray_q` sampled at the edge.
- `single_flip` — output, 1 bit — registered; 1 when the sampled `gray_diff` has exactly one bit set.

## Operation
- **Encode:** `gray[3] = bin[3]`; `gray[i] = bin[i+1] ^ bin[i]` for i = 2..0. Equivalently, `gray = bin ^ (bin >> 1)`.
- **No state on the encode path:**
  - `gray` is valid with no clock toggling and with `rst` at either level.
  - `rst` never affects `gray`.
- **Decode:** `bin_dec[3] = gray_q[3]`; `bin_dec[i] = bin_dec[i+1] ^ gray_q[i]` for i = 2..0.
  - `bin_dec` therefore equals the `bin` sampled at the previous edge.
- **Flip check, at each rising edge:**
  - `gray_diff <= gray ^ gray_q`, using the pre-edge `gray_q`.
  - `single_flip <= (popcount(gray ^ gray_q) == 1)`.
  - `gray_q <= gray`.
- **Holding `bin` constant:** `gray_diff` becomes 0 and `single_flip` becomes 0 on the next edge.
- **Wrap-around:** `bin` 1111 → 0000 gives `gray` 1000 → 0000, which is a single flip. `single_flip` = 1.
- **Non-adjacent step:** for example, 0000 → 0101 gives `gray` 0000 → 0111, so `single_flip` = 0.
- **All 4-bit arithmetic is unsigned, modulo 16.**

## Timing
- `gray`: combinational, 0 cycles. It settles within the propagation delay after any `bin` change.
- `gray_q`, `gray_diff`, `single_flip`: 1-cycle latency and update only on the `clk` rising edge. `bin_dec` follows `gray_q` combinationally.
- **Reset values:** `gray_q` = 0000, `gray_diff` = 0000, `single_flip` = 0, hence `bin_dec` = 0000.
- **Asynchronous reset:**
  - Assertion clears the registered outputs immediately, without waiting for `clk`.
  - Reset mid-stream discards the history. The first edge after deassertion compares against 0000.
- **Reset release:** `rst` deasserting coincident with a clock edge must not corrupt state. That edge either loads normally or is ignored. Integration guarantees release synchronous to `clk`.
- **Simultaneous change:** when `bin` changes at the clock edge, the sampled value obeys normal setup/hold. The block does not arbitrate this.

## Structure
- A shared package holds:
  - the width constant `GRAY_W = 4`;
  - `bin2gray` and `gray2bin` functions, reused by pointer-synchronizer blocks;
  - a popcount-equals-one helper.
- One natural sub-module: `gray_to_bin_4bit`, the combinational decoder driving `bin_dec`.
- The encoder stays inline because it is three XORs.
- One register bank holds `gray_q`, `gray_diff` and `single_flip`, using an asynchronous active-high reset.

## Test plan
1. **Exhaustive combinational encode, no clock, `rst` held either level.** Apply each `bin` value, wait 10 ns, then check `gray`:
   - `bin` 0000–0011 → `gray` 0000, 0001, 0011, 0010.
   - `bin` 0100–0111 → `gray` 0110, 0111, 0101, 0100.
   - `bin` 1000–1011 → `gray` 1100, 1101, 1111, 1110.
   - `bin` 1100–1111 → `gray` 1010, 1011, 1001, 1000.
2. **Reset, then clocked count.** Assert `rst`, then drive `bin` 0→15 with one value per cycle.
   - Each edge: `gray_q` equals the prior `gray`, `bin_dec` equals the prior `bin`, and `single_flip` = 1.
   - `gray_diff` is one-hot at each edge. Examples: 0001 at 0→1, 0010 at 1→2.
3. **Wrap-around.** `bin` 1111 then 0000 → `gray_diff` = 1000, `single_flip` = 1.
4. **Non-adjacent and hold cases.**
   - `bin` 0000 → 0101 → `gray_diff` = 0111, `single_flip` = 0.
   - `bin` held for 3 cycles → `gray_diff` = 0000, `single_flip` = 0.
5. **Asynchronous reset mid-stream.** Assert `rst` between edges while `gray_q` = 1010.
   - Registered outputs go to 0 immediately; `gray` still tracks `bin`.
   - After release, `bin` = 0001 → next edge gives `gray_diff` = 0001, `single_flip` = 1.
